aes_ctr_sequencer: RTL and testbench



---
 rtl/aes_ctr_sequencer.sv | 143 ++++++++++++++
 tb/tb_aes_ctr_sequencer.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_ctr_sequencer.sv
// AES-256 CTR-mode sequencer: drives the cipher core one block at a time
// and XORs the returned keystream onto a valid/ready data stream.
module aes_ctr_sequencer #(
  parameter int CTR_W   = 32,
  parameter int TIMEOUT = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cfg_load,
  input  logic [127:0] cfg_iv,
  input  logic [255:0] cfg_key,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic         in_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         out_last,
  output logic         core_start,
  output logic [127:0] core_block,
  output logic [255:0] core_key,
  input  logic         core_done,
  input  logic [127:0] core_result,
  output logic         busy,
  output logic         err_timeout,
  output logic         err_wrap
);

  localparam int WCW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {S_IDLE, S_GEN, S_WAIT, S_READY, S_OUT} state_t;

  state_t             r_state, w_next;
  logic [127:0]       r_ctr, r_ks, r_out_data;
  logic [255:0]       r_key;
  logic               r_out_valid, r_out_last, r_err_timeout, r_err_wrap;
  logic [WCW-1:0]     r_wait_cnt;

  logic [WCW-1:0]     w_wait_inc;
  logic [CTR_W-1:0]   w_ctr_low_inc;
  logic               w_timeout, w_low_ones;
  logic               w_in_ready, w_core_start, w_busy;

  assign w_wait_inc    = r_wait_cnt + 1'b1;
  // Timeout fires when the post-increment count reaches TIMEOUT-1; a
  // simultaneous core_done takes priority.
  assign w_timeout     = (r_state == S_WAIT) && !core_done &&
                         (w_wait_inc == WCW'(TIMEOUT - 1));
  assign w_ctr_low_inc = r_ctr[CTR_W-1:0] + 1'b1;
  assign w_low_ones    = &r_ctr[CTR_W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    w_in_ready   = 1'b0;
    w_core_start = 1'b0;
    w_busy       = 1'b1;
    case (r_state)
      S_IDLE: begin
        w_busy = 1'b0;
        if (cfg_load) w_next = S_GEN;
      end
      S_GEN: begin
        w_core_start = 1'b1;
        w_next       = S_WAIT;
      end
      S_WAIT: begin
        if (core_done)      w_next = S_READY;
        else if (w_timeout) w_next = S_IDLE;
      end
      S_READY: begin
        w_in_ready = 1'b1;
        if (in_valid) w_next = S_OUT;
      end
      S_OUT: begin
        // A pending wrap ends the session even without in_last.
        if (out_ready) w_next = (r_out_last || r_err_wrap) ? S_IDLE : S_GEN;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ctr         <= '0;
      r_key         <= '0;
      r_ks          <= '0;
      r_out_data    <= '0;
      r_out_valid   <= 1'b0;
      r_out_last    <= 1'b0;
      r_err_timeout <= 1'b0;
      r_err_wrap    <= 1'b0;
      r_wait_cnt    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (cfg_load) begin
            r_ctr         <= cfg_iv;
            r_key         <= cfg_key;
            r_err_timeout <= 1'b0;
            r_err_wrap    <= 1'b0;
          end
        end
        S_GEN: r_wait_cnt <= '0;
        S_WAIT: begin
          r_wait_cnt <= w_wait_inc;
          if (core_done)      r_ks          <= core_result;
          else if (w_timeout) r_err_timeout <= 1'b1;
        end
        S_READY: begin
          if (in_valid) begin
            r_out_data        <= in_data ^ r_ks;
            r_out_last        <= in_last;
            r_out_valid       <= 1'b1;
            r_ctr[CTR_W-1:0]  <= w_ctr_low_inc;
            if (w_low_ones && !in_last) r_err_wrap <= 1'b1;
          end
        end
        S_OUT: begin
          if (out_ready) r_out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign in_ready    = w_in_ready;
  assign core_start  = w_core_start;
  assign busy        = w_busy;
  assign out_valid   = r_out_valid;
  assign out_data    = r_out_data;
  assign out_last    = r_out_last;
  assign core_block  = r_ctr;
  assign core_key    = r_key;
  assign err_timeout = r_err_timeout;
  assign err_wrap    = r_err_wrap;

endmodule

// File: tb/tb_aes_ctr_sequencer.sv
// Directed + randomized bench: a software AES-256 core model answers the
// sequencer, and expected stream outputs come from CTR-mode arithmetic.
module tb_aes_ctr_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, cfg_load, in_valid, in_last, out_ready, core_done, sel;
  logic [127:0] cfg_iv, in_data, core_result;
  logic [255:0] cfg_key;

  logic         a_in_ready, a_out_valid, a_out_last, a_core_start, a_busy, a_err_timeout, a_err_wrap;
  logic [127:0] a_out_data, a_core_block;
  logic [255:0] a_core_key;
  logic         b_in_ready, b_out_valid, b_out_last, b_core_start, b_busy, b_err_timeout, b_err_wrap;
  logic [127:0] b_out_data, b_core_block;
  logic [255:0] b_core_key;

  aes_ctr_sequencer #(.CTR_W(32), .TIMEOUT(64)) u_a (
    .clk(clk), .rst(rst), .cfg_load(cfg_load & ~sel), .cfg_iv(cfg_iv), .cfg_key(cfg_key),
    .in_valid(in_valid & ~sel), .in_ready(a_in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data), .out_last(a_out_last),
    .core_start(a_core_start), .core_block(a_core_block), .core_key(a_core_key),
    .core_done(core_done & ~sel), .core_result(core_result), .busy(a_busy),
    .err_timeout(a_err_timeout), .err_wrap(a_err_wrap));

  aes_ctr_sequencer #(.CTR_W(8), .TIMEOUT(64)) u_b (
    .clk(clk), .rst(rst), .cfg_load(cfg_load & sel), .cfg_iv(cfg_iv), .cfg_key(cfg_key),
    .in_valid(in_valid & sel), .in_ready(b_in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data), .out_last(b_out_last),
    .core_start(b_core_start), .core_block(b_core_block), .core_key(b_core_key),
    .core_done(core_done & sel), .core_result(core_result), .busy(b_busy),
    .err_timeout(b_err_timeout), .err_wrap(b_err_wrap));

  logic         v_in_ready, v_out_valid, v_out_last, v_core_start, v_busy, v_err_timeout, v_err_wrap;
  logic [127:0] v_out_data, v_core_block;
  logic [255:0] v_core_key;
  assign v_in_ready    = sel ? b_in_ready    : a_in_ready;
  assign v_out_valid   = sel ? b_out_valid   : a_out_valid;
  assign v_out_last    = sel ? b_out_last    : a_out_last;
  assign v_core_start  = sel ? b_core_start  : a_core_start;
  assign v_busy        = sel ? b_busy        : a_busy;
  assign v_err_timeout = sel ? b_err_timeout : a_err_timeout;
  assign v_err_wrap    = sel ? b_err_wrap    : a_err_wrap;
  assign v_out_data    = sel ? b_out_data    : a_out_data;
  assign v_core_block  = sel ? b_core_block  : a_core_block;
  assign v_core_key    = sel ? b_core_key    : a_core_key;

  logic [518:0] a_all, b_all;
  assign a_all = {a_in_ready, a_out_valid, a_out_data, a_out_last, a_core_start,
                  a_core_block, a_core_key, a_busy, a_err_timeout, a_err_wrap};
  assign b_all = {b_in_ready, b_out_valid, b_out_data, b_out_last, b_core_start,
                  b_core_block, b_core_key, b_busy, b_err_timeout, b_err_wrap};

  int n_cmp = 0;
  int n_err = 0;

  // ---------------- AES-256 reference core ----------------
  logic [7:0] sbox_t [256];

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  task automatic init_sbox();
    logic [7:0] inv, s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^
          {inv[3:0], inv[7:4]} ^ 8'h63;
      sbox_t[x] = s;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
  endfunction

  function automatic logic [127:0] aes256(input logic [255:0] key, input logic [127:0] pt);
    logic [31:0]  w [60];
    logic [31:0]  t;
    logic [7:0]   rc, a0, a1, a2, a3;
    logic [7:0]   s [16];
    logic [7:0]   u [16];
    logic [127:0] res;
    for (int i = 0; i < 8; i++) w[i] = key[255-32*i -: 32];
    rc = 8'h01;
    for (int i = 8; i < 60; i++) begin
      t = w[i-1];
      if (i % 8 == 0) begin
        t = subw({t[23:0], t[31:24]});
        t[31:24] = t[31:24] ^ rc;
        rc = xt(rc);
      end else if (i % 8 == 4) begin
        t = subw(t);
      end
      w[i] = w[i-8] ^ t;
    end
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) s[4*c+r] = s[4*c+r] ^ w[c][31-8*r -: 8];
    for (int rnd = 1; rnd <= 14; rnd++) begin
      for (int i = 0; i < 16; i++) s[i] = sbox_t[s[i]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) u[4*c+r] = s[4*((c+r)%4)+r];
      for (int i = 0; i < 16; i++) s[i] = u[i];
      if (rnd < 14) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = xt(a0) ^ (xt(a1) ^ a1) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ xt(a1) ^ (xt(a2) ^ a2) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ (xt(a3) ^ a3);
          s[4*c+3] = (xt(a0) ^ a0) ^ a1 ^ a2 ^ xt(a3);
        end
      end
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) s[4*c+r] = s[4*c+r] ^ w[4*rnd+c][31-8*r -: 8];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  // Counter block after one increment of its low `wd` bits.
  function automatic logic [127:0] next_ctr(input logic [127:0] c, input int wd);
    logic [127:0] mask;
    mask = (wd >= 128) ? '1 : ((128'd1 << wd) - 128'd1);
    return (c & ~mask) | ((c + 128'd1) & mask);
  endfunction

  // ---------------- bench helpers ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [639:0] got, input logic [639:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic load(input logic [255:0] k, input logic [127:0] iv);
    cfg_key = k; cfg_iv = iv; cfg_load = 1'b1;
    tick();
    cfg_load = 1'b0;
  endtask

  task automatic wait_start(output int w);
    w = 0;
    while (!v_core_start && w < 20) begin
      tick();
      w++;
    end
    chk("core_start_seen", v_core_start, 1);
  endtask

  // One full block: core launch, keystream return, input transfer, output drain.
  task automatic do_block(input logic [255:0] key, input logic [127:0] blk,
                          input logic [127:0] data, input logic last,
                          input logic [127:0] exp_out, input logic exp_wrap,
                          input int lat, input int stall);
    int w;
    logic [127:0] hold;
    wait_start(w);
    chk("start_latency", w, 0);
    chk("core_block", v_core_block, blk);
    chk("core_key", v_core_key, key);
    repeat (lat) tick();
    chk("in_ready_wait", v_in_ready, 0);
    core_result = aes256(key, blk); core_done = 1'b1;
    tick();
    core_done = 1'b0; core_result = '0;
    chk("in_ready", v_in_ready, 1);
    in_valid = 1'b1; in_data = data; in_last = last;
    tick();
    in_valid = 1'b0;
    chk("out_valid", v_out_valid, 1);
    chk("out_data", v_out_data, exp_out);
    chk("out_last", v_out_last, last);
    chk("in_ready_out", v_in_ready, 0);
    chk("err_wrap_xfer", v_err_wrap, exp_wrap);
    hold = v_out_data;
    for (int i = 0; i < stall; i++) begin
      tick();
      chk("bp_valid", v_out_valid, 1);
      chk("bp_data", v_out_data, exp_out);
      chk("bp_in_ready", v_in_ready, 0);
      chk("bp_core_start", v_core_start, 0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("out_drained", v_out_valid, 0);
  endtask

  localparam logic [255:0] NK  = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [127:0] NIV = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
  localparam logic [127:0] P1  = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] P2  = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
  localparam logic [127:0] C1  = 128'h601ec313775789a5b7a7f504bbf3d228;
  localparam logic [127:0] C2  = 128'hf443e3ca4d62b59aca84e990cacaf5c5;

  initial begin
    logic [255:0] k, k2;
    logic [127:0] iv, iv2, blk, d, junk;
    int n, lat, stall, cyc, w;
    logic saw_ready, saw_start;

    rst = 1'b1; cfg_load = 0; in_valid = 0; in_last = 0; out_ready = 0;
    core_done = 0; sel = 0; cfg_iv = '0; cfg_key = '0; in_data = '0; core_result = '0;
    init_sbox();
    tick(); tick();
    chk("reset_a", a_all, 0);
    chk("reset_b", b_all, 0);
    rst = 1'b0;
    tick();
    chk("idle_a", a_all, 0);

    // NIST single block
    load(NK, NIV);
    do_block(NK, NIV, P1, 1'b1, C1, 1'b0, 2, 0);
    chk("nist1_idle", v_busy, 0);

    // NIST two-block session, with 10 cycles of output backpressure on block 1
    load(NK, NIV);
    do_block(NK, NIV, P1, 1'b0, C1, 1'b0, 3, 10);
    do_block(NK, 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdff00, P2, 1'b1, C2, 1'b0, 1, 0);
    chk("nist2_idle", v_busy, 0);

    // Random sessions against the CTR model
    for (int s = 0; s < 6; s++) begin
      k  = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      iv = {$urandom(), $urandom(), $urandom(), $urandom() & 32'h7fff_ffff};
      n  = $urandom_range(1, 4);
      load(k, iv);
      blk = iv;
      for (int b = 0; b < n; b++) begin
        d     = {$urandom(), $urandom(), $urandom(), $urandom()};
        lat   = $urandom_range(1, 6);
        stall = $urandom_range(0, 3);
        do_block(k, blk, d, (b == n - 1), d ^ aes256(k, blk), 1'b0, lat, stall);
        blk = next_ctr(blk, 32);
      end
      chk("rand_idle", v_busy, 0);
    end

    // Timeout: core never answers
    load(NK, NIV);
    chk("to_start", v_core_start, 1);
    cyc = 0; saw_ready = 0;
    while (!v_err_timeout && cyc < 200) begin
      tick();
      cyc++;
      if (v_in_ready) saw_ready = 1;
    end
    chk("to_cycles", cyc, 64);
    chk("to_busy", v_busy, 0);
    chk("to_in_ready", saw_ready, 0);
    load(NK, NIV);
    chk("to_cleared", v_err_timeout, 0);
    do_block(NK, NIV, P1, 1'b1, C1, 1'b0, 1, 0);

    // Reset in WAIT, then a stray core_done
    load(NK, NIV);
    tick(); tick();
    chk("rst_in_wait_busy", v_busy, 1);
    rst = 1'b1;
    #1;
    chk("rst_async", a_all, 0);
    tick();
    rst = 1'b0;
    core_result = 128'hdead_beef_0000_1111_2222_3333_4444_5555; core_done = 1'b1;
    tick();
    core_done = 1'b0; core_result = '0;
    tick();
    chk("rst_after_done", a_all, 0);

    // cfg_load and core_done in READY are ignored
    k  = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    k2 = ~k;
    iv = {$urandom(), $urandom(), $urandom(), $urandom()};
    iv2 = ~iv;
    load(k, iv);
    wait_start(w);
    tick(); tick();
    core_result = aes256(k, iv); core_done = 1'b1;
    tick();
    core_done = 1'b0;
    chk("ign_in_ready", v_in_ready, 1);
    cfg_key = k2; cfg_iv = iv2; cfg_load = 1'b1;
    junk = {$urandom(), $urandom(), $urandom(), $urandom()};
    core_result = junk; core_done = 1'b1;
    tick();
    cfg_load = 1'b0; core_done = 1'b0; core_result = '0;
    chk("ign_still_ready", v_in_ready, 1);
    chk("ign_key", v_core_key, k);
    chk("ign_ctr", v_core_block, iv);
    d = {$urandom(), $urandom(), $urandom(), $urandom()};
    in_valid = 1'b1; in_data = d; in_last = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("ign_out", v_out_data, d ^ aes256(k, iv));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("ign_idle", v_busy, 0);

    // Counter wrap on the CTR_W=8 instance
    sel = 1'b1;
    iv = {$urandom(), $urandom(), $urandom(), $urandom()};
    iv[7:0] = 8'hff;
    d  = {$urandom(), $urandom(), $urandom(), $urandom()};
    load(NK, iv);
    do_block(NK, iv, d, 1'b0, d ^ aes256(NK, iv), 1'b1, 2, 1);
    chk("wrap_idle", v_busy, 0);
    chk("wrap_flag", v_err_wrap, 1);
    chk("wrap_ctr", v_core_block, {iv[127:8], 8'h00});
    saw_start = 0; saw_ready = 0;
    in_valid = 1'b1; in_data = ~d; in_last = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (v_core_start) saw_start = 1;
      if (v_in_ready) saw_ready = 1;
    end
    in_valid = 1'b0;
    chk("wrap_no_start", saw_start, 0);
    chk("wrap_no_ready", saw_ready, 0);
    chk("wrap_ctr_hold", v_core_block, {iv[127:8], 8'h00});
    sel = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "bench time limit");
  end

endmodule
